multi_button_debouncer: RTL and testbench

MULTI_BUTTON_DEBOUNCER -- requirements
Module: multi_button_debouncer

---
 rtl/multi_button_debouncer.sv | 124 ++++++++++++
 tb/tb_multi_button_debouncer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multi_button_debouncer.sv
// rtl/multi_button_debouncer.sv - N-channel push-button debouncer with press/release pulses
// and a shared up/down press-event counter.
module multi_button_debouncer #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TMR_W           = 20,
  parameter int MAX_COUNT       = 9999,
  parameter int CNT_W           = 14
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [N_BTN-1:0] BTN,
  input  logic             DIR,
  input  logic             CLR,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic             any_held,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} stateT;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);

  logic [N_BTN-1:0] syncA, syncB;
  stateT            state    [N_BTN];
  stateT            stateNxt [N_BTN];
  logic [TMR_W-1:0] tmr      [N_BTN];
  logic [TMR_W-1:0] tmrNxt   [N_BTN];
  logic [N_BTN-1:0] pressEv, releaseEv, dbNxt;

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      stateNxt[i]  = state[i];
      tmrNxt[i]    = tmr[i];
      pressEv[i]   = 1'b0;
      releaseEv[i] = 1'b0;
      // EN low freezes every channel in place, timer included
      if (EN) begin
        case (state[i])
          IDLE: begin
            if (syncB[i]) begin
              stateNxt[i] = PRESS_WAIT;
              tmrNxt[i]   = '0;
            end
          end
          PRESS_WAIT: begin
            if (!syncB[i]) begin
              stateNxt[i] = IDLE;
            end else if (tmr[i] == TMR_LAST) begin
              stateNxt[i] = HELD;
              pressEv[i]  = 1'b1;
            end else begin
              tmrNxt[i] = tmr[i] + 1'b1;
            end
          end
          HELD: begin
            if (!syncB[i]) begin
              stateNxt[i] = RELEASE_WAIT;
              tmrNxt[i]   = '0;
            end
          end
          RELEASE_WAIT: begin
            if (syncB[i]) begin
              stateNxt[i] = HELD;
            end else if (tmr[i] == TMR_LAST) begin
              stateNxt[i]  = IDLE;
              releaseEv[i] = 1'b1;
            end else begin
              tmrNxt[i] = tmr[i] + 1'b1;
            end
          end
          default: stateNxt[i] = IDLE;
        endcase
      end
      dbNxt[i] = (stateNxt[i] == HELD) || (stateNxt[i] == RELEASE_WAIT);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      syncA         <= '0;
      syncB         <= '0;
      btn_db        <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state[i] <= IDLE;
        tmr[i]   <= '0;
      end
    end else begin
      syncA         <= BTN;
      syncB         <= syncA;
      btn_db        <= dbNxt;
      press_pulse   <= pressEv;
      release_pulse <= releaseEv;
      for (int i = 0; i < N_BTN; i++) begin
        state[i] <= stateNxt[i];
        tmr[i]   <= tmrNxt[i];
      end
    end
  end

  // Counter steps on the same edge that raises press_pulse; any number of presses counts once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (CLR) begin
      count <= '0;
    end else if (|pressEv) begin
      if (DIR) begin
        count <= (count == CNT_MAX) ? '0 : count + 1'b1;
      end else begin
        count <= (count == '0) ? CNT_MAX : count - 1'b1;
      end
    end
  end

  assign any_held = |btn_db;

endmodule

// File: tb/tb_multi_button_debouncer.sv
// tb/tb_multi_button_debouncer.sv - self-checking bench for multi_button_debouncer
// against a run-length reference model, with directed literal checks and random stimulus.
module tb_multi_button_debouncer;

  localparam int N    = 3;
  localparam int DEB  = 4;
  localparam int MAXC = 9999;

  logic          CLK, RST, EN, DIR, CLR;
  logic [N-1:0]  BTN;
  logic [N-1:0]  btn_db, press_pulse, release_pulse;
  logic          any_held;
  logic [13:0]   count;

  multi_button_debouncer #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DEB), .TMR_W(3), .MAX_COUNT(MAXC), .CNT_W(14)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .BTN(BTN), .DIR(DIR), .CLR(CLR),
    .btn_db(btn_db), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .any_held(any_held), .count(count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit cmpOn  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a level change is accepted after DEB+1 consecutive enabled samples
  // of the synchronised input disagreeing with the debounced level.
  logic [N-1:0] mS1, mS2, mDb, mPress, mRel, np, nr;
  int           mRun [N];
  int           mCount;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      mS1 = '0; mS2 = '0; mDb = '0; mPress = '0; mRel = '0; mCount = 0;
      for (int i = 0; i < N; i++) mRun[i] = 0;
    end else begin
      np = '0;
      nr = '0;
      if (EN) begin
        for (int i = 0; i < N; i++) begin
          if (mS2[i] != mDb[i]) begin
            mRun[i]++;
            if (mRun[i] == DEB + 1) begin
              mDb[i]  = ~mDb[i];
              mRun[i] = 0;
              if (mDb[i]) np[i] = 1'b1;
              else        nr[i] = 1'b1;
            end
          end else begin
            mRun[i] = 0;
          end
        end
      end
      mPress = np;
      mRel   = nr;
      if (CLR) mCount = 0;
      else if (np != '0) begin
        if (DIR) mCount = (mCount == MAXC) ? 0 : mCount + 1;
        else     mCount = (mCount == 0) ? MAXC : mCount - 1;
      end
      mS2 = mS1;
      mS1 = BTN;
    end
  end

  always @(negedge CLK) begin
    if (cmpOn && !RST) begin
      chk("btn_db", btn_db, mDb);
      chk("press_pulse", press_pulse, mPress);
      chk("release_pulse", release_pulse, mRel);
      chk("any_held", any_held, |mDb);
      chk("count", count, mCount);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Called right after driving at a negedge; the first following posedge is edge 1.
  task automatic expectPulseAt(input logic [N-1:0] expMask, input int edgeNo);
    for (int k = 1; k <= edgeNo; k++) begin
      @(posedge CLK);
      #1;
      if (k == edgeNo - 1) chk("pulse_early", press_pulse, 0);
      if (k == edgeNo)     chk("pulse_edge", press_pulse, expMask);
    end
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; EN = 1'b1; DIR = 1'b1; CLR = 1'b0; BTN = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_btn_db", btn_db, 0);
    chk("rst_press", press_pulse, 0);
    chk("rst_release", release_pulse, 0);
    chk("rst_any_held", any_held, 0);
    chk("rst_count", count, 0);
    @(negedge CLK);
    #1 RST = 1'b0;
    cmpOn = 1'b1;

    // Clean press on channel 0
    @(negedge CLK);
    BTN = 3'b001;
    expectPulseAt(3'b001, 7);
    chk("clean_count", count, 1);
    chk("clean_db", btn_db, 3'b001);

    // Bounce on channel 1: high 3, low 1, then steady
    BTN[1] = 1'b1; step(3);
    BTN[1] = 1'b0; step(1);
    BTN[1] = 1'b1;
    expectPulseAt(3'b010, 7);
    chk("bounce_count", count, 2);

    BTN = '0; step(20);
    chk("release_db", btn_db, 0);

    // Simultaneous press counts once
    BTN = 3'b111;
    expectPulseAt(3'b111, 7);
    chk("simul_count", count, 3);
    chk("simul_any_held", any_held, 1);
    BTN = '0; step(20);

    CLR = 1'b1; step(1); CLR = 1'b0;
    chk("clr_count", count, 0);

    // Wrap both directions
    DIR = 1'b0; BTN[2] = 1'b1; step(10);
    chk("wrap_down", count, 9999);
    BTN = '0; step(10);
    DIR = 1'b1; BTN[2] = 1'b1; step(10);
    chk("wrap_up", count, 0);
    BTN = '0; step(10);

    // Clear overrides a coincident press
    BTN[2] = 1'b1; step(10);
    BTN = '0; step(10);
    BTN[2] = 1'b1; step(6);
    CLR = 1'b1; step(1); CLR = 1'b0;
    chk("clr_press_pulse", press_pulse, 3'b100);
    chk("clr_press_count", count, 0);
    BTN = '0; step(10);

    // EN freeze during PRESS_WAIT with the timer at 2
    BTN[0] = 1'b1; step(5);
    EN = 1'b0; step(10);
    EN = 1'b1;
    expectPulseAt(3'b001, 2);
    chk("en_count", count, 1);
    step(3);

    // Asynchronous reset mid-HELD
    #2 RST = 1'b1;
    #1;
    chk("arst_btn_db", btn_db, 0);
    chk("arst_any_held", any_held, 0);
    chk("arst_count", count, 0);
    chk("arst_release", release_pulse, 0);
    @(negedge CLK);
    #1 RST = 1'b0;
    expectPulseAt(3'b001, 7);

    // Random phase
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, 5) == 0) BTN[ch] = ~BTN[ch];
      EN  = ($urandom_range(0, 9) != 0);
      CLR = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 29) == 0) DIR = ~DIR;
    end
    EN = 1'b1; CLR = 1'b0;
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
